// File: rtl/vend_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vend_input_scheduler
// Purpose  : Coin/item front-end for the vending core. Synchronizes raw
//            buttons and switches, turns coin button presses into single
//            press events, arbitrates them round-robin into a small FIFO and
//            releases one coin event per 1 Hz tick.
// Config   : define DEBOUNCE_EN to build the per-button debounce FSMs;
//            without it a press is the rising edge of the synced button.
// Revision : 1.0 - initial release
// ============================================================================
module vend_input_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          tick,
    input  logic [2:0]                    btn_raw,
    input  logic [3:0]                    sw_raw,
    output logic [2:0]                    coin,
    output logic [3:0]                    item,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);

    localparam int                  c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0]   c_FULL   = (c_ADDR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------------
    logic [2:0] r_btn_s1, r_btn_s2;
    logic [3:0] r_sw_s1, r_sw_s2;

    // Two-flop synchronizers for every raw button and switch bit
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Press detection
    // ------------------------------------------------------------------------
    logic [2:0] w_press;

`ifdef DEBOUNCE_EN
    localparam int                  c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } db_state_t;

    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
        db_state_t          r_state;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_press;

        // Debounce FSM: one press pulse on entry to HELD, none on release
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_press <= 1'b0;
            end else begin
                r_press <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (r_btn_s2[gi]) begin
                            r_state <= S_PRESS_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    S_PRESS_WAIT: begin
                        if (!r_btn_s2[gi]) begin
                            r_state <= S_IDLE;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_HELD;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_HELD: begin
                        if (!r_btn_s2[gi]) begin
                            r_state <= S_RELEASE_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    S_RELEASE_WAIT: begin
                        if (r_btn_s2[gi]) begin
                            r_state <= S_HELD;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign w_press[gi] = r_press;
    end
`else
    logic [2:0] r_btn_d;

    // Delayed copy of the synced buttons for rising-edge detection
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_btn_d <= '0;
        end else begin
            r_btn_d <= r_btn_s2;
        end
    end

    assign w_press = r_btn_s2 & ~r_btn_d;
`endif

    // ------------------------------------------------------------------------
    // Round-robin arbiter and FIFO control
    // ------------------------------------------------------------------------
    logic [2:0]          r_pending;
    logic [1:0]          r_ptr;
    logic [2:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wptr, r_rptr;
    logic [c_ADDR_W:0]   r_level;

    logic                w_empty, w_full, w_pop, w_can_push;
    logic [1:0]          w_cand0, w_cand1, w_cand2;
    logic                w_grant_vld;
    logic [1:0]          w_grant_idx;
    logic [2:0]          w_grant_oh;
    logic [2:0]          w_drop;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == c_FULL);
    assign w_pop      = tick & ~w_empty;
    // A pop on the same edge frees the slot the push will use
    assign w_can_push = ~w_full | w_pop;

    assign w_cand0 = r_ptr;
    assign w_cand1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    assign w_cand2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;

    // Pick the first pending button starting from the round-robin pointer
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_ptr;
        if (w_can_push) begin
            if (r_pending[w_cand0]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand0;
            end else if (r_pending[w_cand1]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand1;
            end else if (r_pending[w_cand2]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand2;
            end
        end
    end

    assign w_grant_oh = w_grant_vld ? (3'b001 << w_grant_idx) : 3'b000;
    // A press only collides with a pending bit that is not leaving this cycle
    assign w_drop     = w_press & r_pending & ~w_grant_oh;

    // Pending bits, round-robin pointer, sticky overflow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pending <= '0;
            r_ptr     <= 2'd0;
            overflow  <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant_oh) | w_press;
            if (w_grant_vld) begin
                r_ptr <= (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
            end
            if (|w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the level gates every read
    always_ff @(posedge clk) begin
        if (w_grant_vld) begin
            r_mem[r_wptr] <= w_grant_oh;
        end
    end

    // FIFO pointers and level; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_grant_vld) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_grant_vld, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Tick-aligned outputs
    // ------------------------------------------------------------------------
    // Coin and item change only on tick and hold for the whole tick period
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            coin <= '0;
            item <= '0;
        end else if (tick) begin
            coin <= w_empty ? 3'b000 : r_mem[r_rptr];
            item <= r_sw_s2;
        end
    end

    assign fifo_level = r_level;
    assign busy       = (r_level != '0) | (|r_pending);

endmodule
`default_nettype wire
